pam_gray_mapper: RTL

Parametrised serial-bit to PAM-M symbol mapper for the transmit side of the FEC datapath. It packs BPS consecutive input bits MSB-first into a symbol, applies a Gray code (or natural binary, selected at run time), and holds the result in a 2-entry output buffer. Both sides use a valid/ready handshake. A flush input emits a zero-padded partial symbol at end of frame.

---
 rtl/pam_gray_mapper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pam_gray_mapper.sv
// Serial-bit to PAM-M symbol mapper with Gray/natural mapping.
// Packs BPS bits MSB-first into a 2-entry valid/ready output buffer.
module pam_gray_mapper #(
  parameter int BPS   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             gray_en,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [BPS-1:0]   out_symbol,
  output logic             out_padded,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sym_count
);

  localparam int PW = (BPS > 1) ? BPS - 1 : 1;
  localparam int CW = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPS - 1);

  typedef struct packed {
    logic [BPS-1:0] sym;
    logic           pad;
  } ent_t;

  function automatic logic [BPS-1:0] map_sym(
    input logic [BPS-1:0] w,
    input logic           g
  );
    return g ? (w ^ (w >> 1)) : w;
  endfunction

  logic [PW-1:0]    partial_q, partial_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_pending_q, flush_pending_d;
  ent_t             e0_q, e0_d;
  ent_t             e1_q, e1_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic           acc;
  logic           pop;
  logic           full;
  logic           last;
  logic           push;
  ent_t           push_ent;
  logic [BPS-1:0] word_full;
  logic [BPS-1:0] word_pad;

  assign full       = (fcnt_q == 2'd2);
  assign in_ready   = rstn && !full && !flush_pending_q;
  assign out_valid  = (fcnt_q != 2'd0);
  assign out_symbol = e0_q.sym;
  assign out_padded = e0_q.pad;
  assign sym_count  = scnt_q;

  assign acc  = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign last = (cnt_q == LAST);

  assign word_full = BPS'({partial_q, in_data});
  // Accepted bits sit right-aligned; shift them up to the MSBs.
  assign word_pad  = BPS'({partial_q, 1'b0} << (LAST - cnt_q));

  always_comb begin
    partial_d       = partial_q;
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q;
    push            = 1'b0;
    push_ent        = '0;
    unique case (1'b1)
      acc && last: begin
        push            = 1'b1;
        push_ent.sym    = map_sym(word_full, gray_en);
        push_ent.pad    = 1'b0;
        cnt_d           = '0;
        partial_d       = '0;
        flush_pending_d = 1'b0;
      end
      acc && !last: begin
        cnt_d           = cnt_q + CW'(1);
        partial_d       = PW'({partial_q, in_data});
        flush_pending_d = flush;
      end
      !acc && flush_pending_q && (cnt_q == '0): begin
        flush_pending_d = 1'b0;
      end
      !acc && flush_pending_q && (cnt_q != '0) && !full: begin
        push            = 1'b1;
        push_ent.sym    = map_sym(word_pad, gray_en);
        push_ent.pad    = 1'b1;
        cnt_d           = '0;
        partial_d       = '0;
        flush_pending_d = 1'b0;
      end
      !acc && !flush_pending_q && flush && (cnt_q != '0): begin
        flush_pending_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    fcnt_d = fcnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (fcnt_q == 2'd0) e0_d = push_ent;
        else                e1_d = push_ent;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        e0_d   = e1_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          e0_d = push_ent;
        end else begin
          e0_d = e1_q;
          e1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  assign scnt_d = pop ? scnt_q + CNT_W'(1) : scnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      partial_q       <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      e0_q            <= '0;
      e1_q            <= '0;
      fcnt_q          <= '0;
      scnt_q          <= '0;
    end else begin
      partial_q       <= partial_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      e0_q            <= e0_d;
      e1_q            <= e1_d;
      fcnt_q          <= fcnt_d;
      scnt_q          <= scnt_d;
    end
  end

endmodule
